// File: rtl/fir_pkg.sv
// Shared constants and helpers for the FIR output path: default widths,
// output saturation limits and the rounding-constant helper.
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;

  localparam logic signed [FIR_OUT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [FIR_OUT_W-1:0] SAT_MIN = 16'sh8000;

  // Half an output LSB expressed in input LSBs; zero when nothing is discarded.
  function automatic logic [63:0] round_const(input int shift);
    logic [63:0] r;
    if (shift > 0) begin
      r = 64'd1 << (shift - 1);
    end else begin
      r = 64'd0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_decim_quant_if.sv
// Valid/ready stream bundle used on both sides of fir_decim_quant.
interface fir_decim_quant_if #(
  parameter int W = 16
) ();
  logic         valid;
  logic [W-1:0] data;
  logic         ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fir_out_fifo.sv
// Synchronous show-ahead FIFO: dout_o always presents the head entry (zero when empty).
module fir_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (count_q == (AW+1)'(DEPTH));
    empty_o  = (count_q == '0);
    do_pop   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    dout_o   = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_decim_quant.sv
// FIR output stage: round, shift, saturate, decimate by N, buffer in a show-ahead FIFO.
// Define FIR_DECIM_QUANT_CONV_ROUND_EN for round-half-to-even instead of round-half-up.
module fir_decim_quant
  import fir_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = FIR_IN_W,
  parameter int DATA_OUT_WIDTH = FIR_OUT_W,
  parameter int SHIFT          = 6,
  parameter int DECIM_WIDTH    = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fir_decim_quant_if.slave       in_s,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  input  logic                   clr_i,
  fir_decim_quant_if.master      out_m,
  output logic                   overflow_o,
  output logic                   drop_o
);

  localparam int EXT_W = DATA_IN_WIDTH + 1;

  localparam logic signed [EXT_W-1:0] RND = $signed(EXT_W'(round_const(SHIFT)));
  localparam logic signed [EXT_W-1:0] Q_MAX =
    $signed({{(EXT_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}});
  localparam logic signed [EXT_W-1:0] Q_MIN =
    $signed({{(EXT_W-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}});
  localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};

`ifdef FIR_DECIM_QUANT_CONV_ROUND_EN
  localparam logic [DATA_IN_WIDTH-1:0] FRAC_MASK = DATA_IN_WIDTH'((64'd1 << SHIFT) - 64'd1);
  localparam logic [DATA_IN_WIDTH-1:0] HALF_LSB  = DATA_IN_WIDTH'(round_const(SHIFT));
`endif

  logic signed [EXT_W-1:0]    sum_ext, q_shift, q_rnd;
  logic                       sat_hi, sat_lo;
  logic [DATA_OUT_WIDTH-1:0]  quant;

  logic [DECIM_WIDTH-1:0]     neff_m1;
  logic                       keep;
  logic [DECIM_WIDTH-1:0]     cnt_q, cnt_d;
  logic                       s1_valid_q, s1_valid_d;
  logic [DATA_OUT_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic                       overflow_q, overflow_d;
  logic                       drop_q, drop_d;

  logic                       fifo_full, fifo_empty, pop;
  logic [DATA_OUT_WIDTH-1:0]  fifo_dout;

  // The input side never stalls; the bundle's ready is tied high.
  assign in_s.ready = 1'b1;

  always_comb begin
    sum_ext = $signed({in_s.data[DATA_IN_WIDTH-1], in_s.data}) + RND;
    q_shift = sum_ext >>> SHIFT;
    q_rnd   = q_shift;
`ifdef FIR_DECIM_QUANT_CONV_ROUND_EN
    // On an exact half, half-up landed on the upper neighbour; clearing the
    // LSB of an odd result steps back down to the even one.
    if ((SHIFT > 0) && ((in_s.data & FRAC_MASK) == HALF_LSB)) begin
      q_rnd[0] = 1'b0;
    end
`endif
    sat_hi = (q_rnd > Q_MAX);
    sat_lo = (q_rnd < Q_MIN);
    if (sat_hi) begin
      quant = OUT_MAX;
    end else if (sat_lo) begin
      quant = OUT_MIN;
    end else begin
      quant = q_rnd[DATA_OUT_WIDTH-1:0];
    end
  end

  always_comb begin
    neff_m1 = (decim_i == '0) ? '0 : decim_i - DECIM_WIDTH'(1);
    keep    = in_s.valid && (cnt_q == '0);
    cnt_d   = cnt_q;
    // '>=' rather than '==' so a shrinking N recovers on the next valid.
    if (in_s.valid) begin
      cnt_d = (cnt_q >= neff_m1) ? '0 : cnt_q + DECIM_WIDTH'(1);
    end
    s1_valid_d = keep;
    s1_data_d  = keep ? quant : s1_data_q;
    pop        = out_m.valid && out_m.ready;
    overflow_d = (overflow_q && !clr_i) || (in_s.valid && (sat_hi || sat_lo));
    drop_d     = (drop_q && !clr_i) || (s1_valid_q && fifo_full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  fir_out_fifo #(
    .WIDTH (DATA_OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (s1_valid_q),
    .din_i   (s1_data_q),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_m.valid = !fifo_empty;
  assign out_m.data  = fifo_dout;
  assign overflow_o  = overflow_q;
  assign drop_o      = drop_q;

endmodule
